flex_updown_counter: RTL and testbench



---
 rtl/flex_updown_counter.sv | 81 ++++++++
 tb/tb_flex_updown_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// N-bit up/down counter with programmable rollover, synchronous clear/load,
// registered rollover flag and wrap pulse. Define FLEX_CNT_SAT_EN for saturating mode.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] One = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_d, count_q;
  logic                    flag_d, flag_q;
  logic                    wrap_d, wrap_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    wrap_d  = 1'b0;

    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_enable && (rollover_val != '0)) begin
      if (!count_down) begin
        if (count_q >= rollover_val) begin
`ifdef FLEX_CNT_SAT_EN
          count_d = rollover_val;
`else
          count_d = One;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q <= One) begin
`ifdef FLEX_CNT_SAT_EN
          count_d = count_q;
`else
          count_d = rollover_val;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - One;
        end
      end
    end

    // Flag derives from the next count so it lines up with count_out after the edge.
    flag_d = (count_d == rollover_val) && (rollover_val != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      count_q <= count_d;
      flag_q  <= flag_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed self-checking bench for flex_updown_counter (N = 4); covers the
// wrap build by default and the FLEX_CNT_SAT_EN build when that macro is defined.
module tb_flex_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       count_enable;
  logic       count_down;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;

  int n_total = 0;
  int n_bad   = 0;

  flex_updown_counter #(.NUM_CNT_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_down   (count_down),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int c, input int f, input int w);
    check({tag, " cnt"},  int'(count_out),     c);
    check({tag, " flag"}, int'(rollover_flag), f);
    check({tag, " wrap"}, int'(wrap_pulse),    w);
  endtask

  // Advance one edge and sample 1 ns later, well away from the next edge.
  task automatic step(input string tag, input int c, input int f, input int w);
    @(posedge clk);
    #1;
    check_outs(tag, c, f, w);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
    count_enable = 1'b0; count_down = 1'b0; rollover_val = 4'd10;
    #12;
    check_outs("reset", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Count to 5, then reset mid-cycle: outputs must clear without a clock.
    count_enable = 1'b1;
    for (int i = 1; i <= 5; i++) step("pre_rst", i, 0, 0);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 0, 0, 0);
    step("rst_hold1", 0, 0, 0);
    step("rst_hold2", 0, 0, 0);
    rst = 1'b0; count_enable = 1'b0;
    step("rst_release", 0, 0, 0);
    count_enable = 1'b1;
    step("first_en", 1, 0, 0);
    count_enable = 1'b0; clear = 1'b1;
    step("clr0", 0, 0, 0);
    clear = 1'b0;

`ifndef FLEX_CNT_SAT_EN
    // Up wrap, R = 3
    rollover_val = 4'd3; count_enable = 1'b1; count_down = 1'b0;
    step("up1", 1, 0, 0);
    step("up2", 2, 0, 0);
    step("up3", 3, 1, 0);
    step("up4", 1, 0, 1);
    step("up5", 2, 0, 0);
    step("up6", 3, 1, 0);
    step("up7", 1, 0, 1);

    // Down wrap, R = 10, from a load of 2
    count_enable = 1'b0; rollover_val = 4'd10; load = 1'b1; load_val = 4'd2;
    step("dn_load", 2, 0, 0);
    load = 1'b0; count_enable = 1'b1; count_down = 1'b1;
    step("dn1", 1, 0, 0);
    step("dn2", 10, 1, 1);
    step("dn3", 9, 0, 0);
    step("dn4", 8, 0, 0);

    // Priority: clear beats load beats enable
    count_enable = 1'b0; load = 1'b1; load_val = 4'd6;
    step("pri_load6", 6, 0, 0);
    clear = 1'b1; load_val = 4'd9; count_enable = 1'b1; count_down = 1'b0;
    step("pri_all", 0, 0, 0);
    clear = 1'b0; count_enable = 1'b0;
    step("pri_load9", 9, 0, 0);

    // Out-of-range load, then rollover_val = 0
    rollover_val = 4'd4; load_val = 4'd12;
    step("oor_load", 12, 0, 0);
    load = 1'b0; count_enable = 1'b1;
    step("oor_up", 1, 0, 1);
    rollover_val = 4'd0;
    for (int i = 0; i < 5; i++) step("r_zero", 1, 0, 0);

    // Down step from 0 goes to R; loading R raises the flag on the same edge
    count_enable = 1'b0; clear = 1'b1;
    step("clr1", 0, 0, 0);
    clear = 1'b0; rollover_val = 4'd6; count_enable = 1'b1; count_down = 1'b1;
    step("dn_from0", 6, 1, 1);
    count_enable = 1'b0; load = 1'b1; load_val = 4'd5;
    step("load5", 5, 0, 0);
    load_val = 4'd6;
    step("load_r", 6, 1, 0);
    load = 1'b0;
    step("hold", 6, 1, 0);
`else
    // Saturating build, R = 5
    rollover_val = 4'd5; count_enable = 1'b1; count_down = 1'b0;
    for (int i = 1; i <= 8; i++) step("sat_up", (i > 5) ? 5 : i, (i >= 5) ? 1 : 0, 0);
    count_down = 1'b1;
    for (int i = 1; i <= 6; i++) step("sat_dn", (i > 4) ? 1 : 5 - i, 0, 0);
    count_down = 1'b0; rollover_val = 4'd4; load = 1'b1; load_val = 4'd12;
    step("sat_oor_load", 12, 0, 0);
    load = 1'b0;
    step("sat_oor_up", 4, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
